// File: rtl/crack_sched.sv
// Key-search scheduler: sweeps candidate keys 0..KEY_MAX across N_CH crack engines
// and reports the first verified key, or exhaustion.
module crack_sched #(
   parameter int              KEY_W   = 24,
   parameter int              N_CH    = 2,
   parameter logic [KEY_W-1:0] KEY_MAX = {KEY_W{1'b1}}
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   output logic                   rdy,
   output logic [KEY_W-1:0]       key,
   output logic                   key_valid,
   output logic                   done,
   output logic [N_CH-1:0]        ch_en,
   output logic [N_CH*KEY_W-1:0]  ch_key,
   input  logic [N_CH-1:0]        ch_rdy,
   input  logic [N_CH-1:0]        ch_done,
   input  logic [N_CH-1:0]        ch_hit
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   // One extra bit lets the counter step past KEY_MAX without wrapping.
   localparam logic [KEY_W:0] KEY_LAST = {1'b0, KEY_MAX};

   state_t            state_r;
   state_t            state_next_s;
   logic [KEY_W:0]    cnt_r;
   logic [N_CH-1:0]   busy_r;
   logic              found_r;
   logic [N_CH-1:0]   free_s;
   logic [N_CH-1:0]   disp_oh_s;
   logic              disp_s;
   logic              start_s;
   logic              run_s;
   logic              hit_s;
   logic              exhaust_s;
   logic [KEY_W-1:0]  hit_key_s;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE, FIN: state_next_s = start_s ? RUN : state_r;
         RUN:       state_next_s = (hit_s || exhaust_s) ? DRAIN : RUN;
         DRAIN:     state_next_s = (busy_r == {N_CH{1'b0}}) ? FIN : DRAIN;
         default:   state_next_s = IDLE;
      endcase
   end

   // Hit arbitration and dispatch selection; lowest channel index wins both
   always_comb begin
      start_s   = en & rdy;
      run_s     = (state_r == RUN);
      exhaust_s = (cnt_r > KEY_LAST);
      hit_s     = 1'b0;
      hit_key_s = {KEY_W{1'b0}};
      for (int i = N_CH - 1; i >= 0; i--) begin
         hit_key_s = (ch_done[i] && busy_r[i] && ch_hit[i]) ? ch_key[i*KEY_W +: KEY_W] : hit_key_s;
         hit_s     = hit_s | (ch_done[i] & busy_r[i] & ch_hit[i]);
      end
      free_s    = ch_rdy & ~busy_r;
      disp_oh_s = (run_s && !hit_s && !exhaust_s) ? (free_s & (~free_s + N_CH'(1'b1)))
                                                  : {N_CH{1'b0}};
      disp_s    = |disp_oh_s;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy       <= 1'b1;
         key       <= {KEY_W{1'b0}};
         key_valid <= 1'b0;
         done      <= 1'b0;
         ch_en     <= {N_CH{1'b0}};
         ch_key    <= {(N_CH*KEY_W){1'b0}};
         busy_r    <= {N_CH{1'b0}};
         cnt_r     <= {(KEY_W+1){1'b0}};
         found_r   <= 1'b0;
      end else begin
         rdy    <= (state_next_s == IDLE) || (state_next_s == FIN);
         ch_en  <= disp_oh_s;
         busy_r <= (busy_r & ~ch_done) | disp_oh_s;
         for (int i = 0; i < N_CH; i++) begin
            if (disp_oh_s[i]) begin
               ch_key[i*KEY_W +: KEY_W] <= cnt_r[KEY_W-1:0];
            end
         end
         if (start_s) begin
            cnt_r     <= {(KEY_W+1){1'b0}};
            key       <= {KEY_W{1'b0}};
            key_valid <= 1'b0;
            done      <= 1'b0;
            found_r   <= 1'b0;
         end else begin
            if (disp_s) begin
               cnt_r <= cnt_r + {{KEY_W{1'b0}}, 1'b1};
            end
            if (run_s && hit_s && !found_r) begin
               key     <= hit_key_s;
               found_r <= 1'b1;
            end
            if ((state_r == DRAIN) && (busy_r == {N_CH{1'b0}})) begin
               done      <= 1'b1;
               key_valid <= found_r;
            end
         end
      end
   end

endmodule

// File: tb/tb_crack_sched.sv
// Directed self-checking bench for crack_sched with two modelled crack engines
// (KEY_W=4, N_CH=2, KEY_MAX=15).
module tb_crack_sched;

   logic        clk;
   logic        rst;
   logic        en;
   logic        rdy;
   logic [3:0]  key;
   logic        key_valid;
   logic        done;
   logic [1:0]  ch_en;
   logic [7:0]  ch_key;
   logic [1:0]  ch_rdy;
   logic [1:0]  ch_done;
   logic [1:0]  ch_hit;

   int          n_chk;
   int          n_fail;
   logic [15:0] hit_map;
   int          lat [2];
   int          cd [2];
   logic [3:0]  kl [2];
   int          n_disp;
   int          n_ch [2];
   int          seq_err;
   int          alt_err;
   int          exp_next;
   int          both_hit;
   bit          alt_chk;

   crack_sched #(.KEY_W(4), .N_CH(2), .KEY_MAX(4'd15)) dut (
      .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .key_valid(key_valid),
      .done(done), .ch_en(ch_en), .ch_key(ch_key), .ch_rdy(ch_rdy),
      .ch_done(ch_done), .ch_hit(ch_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_stats();
      n_disp   = 0;
      n_ch[0]  = 0;
      n_ch[1]  = 0;
      seq_err  = 0;
      alt_err  = 0;
      exp_next = 0;
      both_hit = 0;
   endtask

   task automatic start_search();
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 400 && !seen; c++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   // Engine model and dispatch monitor: done pulse a fixed latency after ch_en
   initial begin
      ch_done = 2'b00;
      ch_hit  = 2'b00;
      cd[0] = 0;
      cd[1] = 0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            ch_done[i] = 1'b0;
            ch_hit[i]  = 1'b0;
            if (cd[i] != 0) begin
               cd[i]--;
               if (cd[i] == 0) begin
                  ch_done[i] = 1'b1;
                  ch_hit[i]  = hit_map[kl[i]];
               end
            end
            if (ch_en[i] === 1'b1) begin
               cd[i] = lat[i];
               kl[i] = ch_key[i*4 +: 4];
               n_disp++;
               n_ch[i]++;
               if (int'(kl[i]) != exp_next) seq_err++;
               if (alt_chk && (i != int'(kl[i][0]))) alt_err++;
               exp_next++;
            end
         end
         if (ch_done == 2'b11 && ch_hit == 2'b11) both_hit++;
      end
   end

   initial begin
      bit seen;
      n_chk   = 0;
      n_fail  = 0;
      rst     = 1'b1;
      en      = 1'b0;
      ch_rdy  = 2'b11;
      hit_map = 16'h0000;
      lat[0]  = 3;
      lat[1]  = 3;
      alt_chk = 1'b0;
      clear_stats();
      repeat (3) @(negedge clk);
      check("rst_rdy", rdy, 1);
      check("rst_done", done, 0);
      check("rst_kv", key_valid, 0);
      check("rst_key", key, 0);
      check("rst_ch_en", ch_en, 0);
      check("rst_ch_key", ch_key, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Hit on key 9 only, alternating engines
      hit_map = 16'h0200;
      alt_chk = 1'b1;
      clear_stats();
      start_search();
      wait_done("t1");
      check("t1_done", done, 1);
      check("t1_kv", key_valid, 1);
      check("t1_key", key, 9);
      check("t1_ndisp", n_disp, 10);
      check("t1_seq", seq_err, 0);
      check("t1_alt", alt_err, 0);
      check("t1_rdy", rdy, 1);
      alt_chk = 1'b0;

      // No hits: full sweep 0..15
      hit_map = 16'h0000;
      clear_stats();
      start_search();
      wait_done("t2");
      check("t2_ndisp", n_disp, 16);
      check("t2_seq", seq_err, 0);
      check("t2_done", done, 1);
      check("t2_kv", key_valid, 0);
      check("t2_key", key, 0);
      check("t2_rdy", rdy, 1);

      // Same-cycle hits on keys 6 (ch0) and 7 (ch1)
      lat[0]  = 4;
      lat[1]  = 3;
      hit_map = 16'h00C0;
      clear_stats();
      start_search();
      wait_done("t3");
      check("t3_both", both_hit, 1);
      check("t3_key", key, 6);
      check("t3_kv", key_valid, 1);
      check("t3_ndisp", n_disp, 8);

      // ch0 never ready
      lat[0]  = 3;
      lat[1]  = 3;
      ch_rdy  = 2'b10;
      hit_map = 16'h0000;
      clear_stats();
      start_search();
      wait_done("t4");
      check("t4_ch0", n_ch[0], 0);
      check("t4_ch1", n_ch[1], 16);
      check("t4_seq", seq_err, 0);
      check("t4_done", done, 1);
      check("t4_kv", key_valid, 0);

      // Reset mid-RUN with ch1 busy
      ch_rdy = 2'b11;
      clear_stats();
      start_search();
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (n_ch[1] > 0) seen = 1'b1;
      end
      check("t5_ch1_disp", seen, 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("t5_rdy", rdy, 1);
      check("t5_ch_en", ch_en, 0);
      check("t5_done", done, 0);
      check("t5_ch_key", ch_key, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_stats();
      repeat (8) @(negedge clk);
      check("t5_idle_disp", n_disp, 0);
      check("t5_idle_rdy", rdy, 1);
      hit_map = 16'h0001;
      clear_stats();
      start_search();
      wait_done("t5");
      check("t5_key", key, 0);
      check("t5_kv", key_valid, 1);
      check("t5_seq", seq_err, 0);
      check("t5_ndisp", n_disp, 2);

      // en held high through RUN/DRAIN, then a fresh en in FIN
      hit_map = 16'h0008;
      clear_stats();
      @(negedge clk);
      en = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
         @(negedge clk);
         if (rdy === 1'b1) seen = 1'b1;
      end
      en = 1'b0;
      check("t6_fin", seen, 1);
      repeat (2) @(negedge clk);
      check("t6_done", done, 1);
      check("t6_kv", key_valid, 1);
      check("t6_key", key, 3);
      check("t6_ndisp", n_disp, 4);
      check("t6_seq", seq_err, 0);
      clear_stats();
      start_search();
      check("t6_restart_done", done, 0);
      check("t6_restart_kv", key_valid, 0);
      check("t6_restart_rdy", rdy, 0);
      wait_done("t6b");
      check("t6b_key", key, 3);
      check("t6b_ndisp", n_disp, 4);
      check("t6b_seq", seq_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/crack_sched.md
CRACK_SCHED -- requirements
Module: crack_sched

Interface
REQ-001 SHALL have parameter KEY_W, default 24, meaning key width in bits.
REQ-002 SHALL have parameter N_CH, default 2, meaning number of attached crack engines (1..8).
REQ-003 SHALL have parameter KEY_MAX, default 2**KEY_W-1, meaning last candidate key searched.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  start request, honoured only while rdy=1.
REQ-007 SHALL have port rdy  output  1  high when a new search can be started.
REQ-008 SHALL have port key  output  KEY_W  key found by the last search.
REQ-009 SHALL have port key_valid  output  1  high when key holds a verified key.
REQ-010 SHALL have port done  output  1  high when the last search finished (found or exhausted).
REQ-011 SHALL have port ch_en  output  N_CH  per-engine one-cycle start pulse.
REQ-012 SHALL have port ch_key  output  N_CH*KEY_W  per-engine candidate key; slice i = bits [i*KEY_W +: KEY_W].
REQ-013 SHALL have port ch_rdy  input  N_CH  per-engine ready.
REQ-014 SHALL have port ch_done  input  N_CH  per-engine one-cycle completion pulse.
REQ-015 SHALL have port ch_hit  input  N_CH  per-engine result, sampled only with ch_done (1 = key decrypts to valid text).

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN, FIN; rdy=1 in IDLE and FIN only.
REQ-017 SHALL, on en=1 with rdy=1, clear key, key_valid, done, load candidate counter to 0, enter RUN.
REQ-018 SHALL keep candidate counter KEY_W+1 bits wide so passing KEY_MAX (including KEY_MAX = 2**KEY_W-1) never wraps to 0.
REQ-019 SHALL in RUN dispatch at most one candidate per cycle, to the lowest-index channel i with ch_rdy[i]=1 and busy[i]=0.
REQ-020 SHALL on dispatch: register ch_en[i]=1 for exactly one cycle, drive ch_key slice i with the candidate, set busy[i], increment counter.
REQ-021 SHALL hold each ch_key slice stable until the next dispatch to that channel.
REQ-022 SHALL clear busy[i] on ch_done[i]=1; ch_done on a non-busy channel SHALL be ignored.
REQ-023 SHALL on ch_done[i]=1 with ch_hit[i]=1 and no hit recorded yet, record that channel's ch_key as key, stop dispatching, enter DRAIN.
REQ-024 SHALL resolve simultaneous hits in favour of the lowest channel index.
REQ-025 SHALL, once the counter exceeds KEY_MAX in RUN, stop dispatching and enter DRAIN.
REQ-026 SHALL in DRAIN issue no ch_en and ignore further hits; when all busy bits are 0, enter FIN next cycle.
REQ-027 SHALL in FIN assert done=1, key_valid=1 iff a hit was recorded (key=0 otherwise), and hold both until the next accepted en.
REQ-028 SHALL accept en in FIN, acting exactly as from IDLE.
REQ-029 SHALL ignore en while in RUN or DRAIN.

Reset
REQ-030 SHALL on rst=1, asynchronously and mid-search included, force IDLE, rdy=1, key=0, key_valid=0, done=0, ch_en=0, ch_key=0, busy=0, counter=0.
REQ-031 SHALL on rst release wait for a fresh en before dispatching; engine pulses arriving after reset SHALL be ignored (busy=0).

Verification (KEY_W=4, N_CH=2, KEY_MAX=15)
REQ-032 SHALL cover: reset, en pulse, both ch_rdy=1, engines reply ch_done 3 cycles after ch_en, hit only for key 9 -> ch_key sequence 0,1,2,... alternating ch0/ch1, done=1, key_valid=1, key=9, no dispatch after hit.
REQ-033 SHALL cover: no hits -> exactly 16 dispatches (keys 0..15, no repeat), done=1, key_valid=0, key=0, rdy=1.
REQ-034 SHALL cover: same-cycle hits on ch0 (key 6) and ch1 (key 7) -> key=6.
REQ-035 SHALL cover: ch_rdy[0]=0 permanently -> all 16 candidates go to ch1, ch_en[0] never high.
REQ-036 SHALL cover: rst=1 asserted mid-RUN with ch1 busy -> same cycle rdy=1, ch_en=0, done=0; late ch_done[1] ignored; new en restarts at key 0.
REQ-037 SHALL cover: en held high during RUN -> no restart; en in FIN -> key_valid/done clear next cycle, new search from key 0.
